// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM stage of the 16-bit pipelined core. Issues data-memory
//                loads/stores over a req/ack handshake, stalls EX/MEM while
//                an access is outstanding, registers the MEM/WB boundary,
//                drives the output port and keeps the sticky halt flag.
//                Optional feature macro: DMEM_TIMEOUT_EN (bounded wait for
//                dmem_ack, reported through the sticky bus_err flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ALUres_mem,
    input  logic        S_mem,
    input  logic        C_mem,
    input  logic        Z_mem,
    input  logic        V_mem,
    input  logic [15:0] pcinc_mem,
    input  logic [15:0] rd1_mem,
    input  logic [15:0] extended_d_mem,
    input  logic [2:0]  regwrite_adr_mem,
    input  logic        main_mem_write,
    input  logic        from_main_mem_mem,
    input  logic [1:0]  regwrite_dat_controll,
    input  logic        regwrite_mem,
    input  logic        is_halt,
    input  logic        out_en,
    input  logic [15:0] out_dat,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_adr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_mem,
    output logic [15:0] wb_dat,
    output logic [2:0]  wb_adr,
    output logic        wb_regwrite,
    output logic [3:0]  wb_flags,
    output logic [15:0] out_port,
    output logic        out_valid,
    output logic        halted,
    output logic        bus_err
);

    // The timeout count must fit its counter and be at least one cycle.
    generate
        if ((TIMEOUT < 1) || (TIMEOUT >= (1 << TO_W))) begin : g_bad_timeout
            $error("mem_stage: TIMEOUT must be in 1 .. 2**TO_W-1");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_halted;
    logic [15:0] r_wb_dat;
    logic [2:0]  r_wb_adr;
    logic        r_wb_regwrite;
    logic [3:0]  r_wb_flags;
    logic [15:0] r_out_port;
    logic        r_out_valid;

    logic        w_memop;
    logic        w_stall;
    logic        w_timeout;
    logic [15:0] w_wb_sel;

    // A halted core issues no further memory traffic; an outstanding access
    // stalls the pipeline until the cycle in which it is acknowledged.
    assign w_memop    = (main_mem_write | from_main_mem_mem) & ~r_halted;
    assign w_stall    = w_memop & ~dmem_ack;

    assign dmem_req   = w_memop;
    assign dmem_we    = main_mem_write;
    assign dmem_adr   = ALUres_mem;
    assign dmem_wdata = rd1_mem;
    assign stall_mem  = w_stall;

    // Write-back source select; load data is taken in the ack cycle.
    always_comb begin
        w_wb_sel = ALUres_mem;
        case (regwrite_dat_controll)
            2'b00:   w_wb_sel = ALUres_mem;
            2'b01:   w_wb_sel = dmem_rdata;
            2'b10:   w_wb_sel = pcinc_mem;
            default: w_wb_sel = extended_d_mem;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_to_one  = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] r_to_cnt;
    logic            r_bus_err;

    // The access is abandoned on the edge at which the BUSY count reaches TIMEOUT.
    assign w_timeout = (r_state == BUSY) & w_stall & (r_to_cnt == c_to_last);

    // Count un-acknowledged BUSY cycles; restart on ack, idle or abandon.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == BUSY) && w_stall && !w_timeout) begin
            r_to_cnt <= r_to_cnt + c_to_one;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Sticky bus error once an access has been abandoned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Handshake tracker: BUSY while a request waits for its ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_stall || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky halt: set by a non-stalled halt instruction or an abandoned access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halted <= 1'b0;
        end else if ((is_halt && !w_stall) || w_timeout) begin
            r_halted <= 1'b1;
        end
    end

    // MEM/WB register: bubble while stalled or halted, otherwise advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_dat      <= '0;
            r_wb_adr      <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_flags    <= '0;
        end else if (r_halted || w_stall) begin
            r_wb_regwrite <= 1'b0;
        end else begin
            r_wb_dat      <= w_wb_sel;
            r_wb_adr      <= regwrite_adr_mem;
            r_wb_regwrite <= regwrite_mem;
            r_wb_flags    <= {S_mem, C_mem, Z_mem, V_mem};
        end
    end

    // Output port register with a single-cycle valid pulse per update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_port  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (out_en && !w_stall && !r_halted) begin
                r_out_port  <= out_dat;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign wb_dat      = r_wb_dat;
    assign wb_adr      = r_wb_adr;
    assign wb_regwrite = r_wb_regwrite;
    assign wb_flags    = r_wb_flags;
    assign out_port    = r_out_port;
    assign out_valid   = r_out_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire
